scramble_cipher_gen: RTL and testbench

- Parametrised next-generation word scrambler for the ITC-style benchmark set.
- Accepts W-bit words over a valid/ready input handshake and keeps a rolling key.
- Control words (all-zeros or all-ones) advance the key and pass through unchanged; in-range words are enciphered with modulo-MOD arithmetic; out-of-range words are dropped.
- Results leave on a valid/ready output handshake with backpressure.

---
 rtl/scramble_cipher_gen.sv | 156 +++++++++++++++
 tb/tb_scramble_cipher_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scramble_cipher_gen.sv
// Word scrambler: control words advance a rolling key, in-range words are enciphered mod MOD.
// Optional saturating drop counter output is enabled with `define SCRAMBLE_DROP_CNT_EN.
module scramble_cipher_gen #(
    parameter int W       = 6,
    parameter int MOD     = 26,
    parameter int KEY_MAX = 25,
    parameter int AW      = W + 3,
    parameter int OFS0    = -21,
    parameter int OFS1    = -42,
    parameter int OFS2    = 7,
    parameter int OFS3    = 28,
    localparam int KW     = $clog2(KEY_MAX + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  x_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  x_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW-1:0] key_out,
`ifdef SCRAMBLE_DROP_CNT_EN
    output logic [W-1:0]  drop_cnt,
`endif
    output logic [3:0]    state_dbg
);

    // Handshakes: a word moves on any rising edge where valid && ready are both high;
    // x_out/out_valid stay stable while out_valid is high and out_ready is low.

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_DATAIN  = 4'd1,
        S_SPAZIO  = 4'd2,
        S_MUL     = 4'd3,
        S_SOMMA   = 4'd4,
        S_RSUM    = 4'd5,
        S_RSOT    = 4'd6,
        S_COMPL   = 4'd7,
        S_DATAOUT = 4'd8,
        S_HOLD    = 4'd9
    } state_t;

    localparam logic [AW-1:0] MOD_A     = AW'(MOD);
    localparam logic [AW-1:0] WORD_MAX  = AW'((1 << W) - 1);
    localparam logic [KW-1:0] KEY_MAX_K = KW'(KEY_MAX);

    state_t         state;
    logic [W-1:0]   r_in;
    logic [KW-1:0]  key;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  ofs_sel;

    always_comb begin
        ofs_sel = AW'(OFS0);
        case (r_in[3:2])
            2'd0:    ofs_sel = AW'(OFS0);
            2'd1:    ofs_sel = AW'(OFS1);
            2'd2:    ofs_sel = AW'(OFS2);
            default: ofs_sel = AW'(OFS3);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_RESET;
            r_in      <= '0;
            key       <= '0;
            acc       <= '0;
            x_out     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
`ifdef SCRAMBLE_DROP_CNT_EN
            drop_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    key   <= '0;
                    x_out <= '0;
                    state <= S_DATAIN;
                end
                S_DATAIN: begin
                    if (in_valid && in_ready) begin
                        r_in     <= x_in;
                        in_ready <= 1'b0;
                        state    <= S_SPAZIO;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_SPAZIO: begin
                    if (r_in == '0 || r_in == '1) begin
                        key   <= (key < KEY_MAX_K) ? key + 1'b1 : '0;
                        acc   <= AW'(r_in);
                        state <= S_DATAOUT;
                    end else if (AW'(r_in) <= MOD_A) begin
                        state <= S_MUL;
                    end else begin
                        state <= S_DATAIN;
`ifdef SCRAMBLE_DROP_CNT_EN
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`endif
                    end
                end
                S_MUL: begin
                    acc   <= r_in[0] ? AW'({key, 1'b0}) : AW'(key);
                    state <= S_SOMMA;
                end
                S_SOMMA: begin
                    if (r_in[1]) begin
                        acc   <= AW'(r_in) + acc;
                        state <= S_RSUM;
                    end else begin
                        acc   <= AW'(r_in) - acc;
                        state <= S_RSOT;
                    end
                end
                S_RSUM: begin
                    if (acc > MOD_A) acc <= acc - MOD_A;
                    else state <= S_COMPL;
                end
                // Negative accumulator values read as large unsigned, so one compare catches them.
                S_RSOT: begin
                    if (acc > WORD_MAX) acc <= acc + MOD_A;
                    else state <= S_COMPL;
                end
                S_COMPL: begin
                    acc   <= acc + ofs_sel;
                    state <= S_DATAOUT;
                end
                S_DATAOUT: begin
                    x_out     <= acc[AW-1] ? (W'(0) - acc[W-1:0]) : acc[W-1:0];
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_DATAIN;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_RESET;
                end
            endcase
        end
    end

    assign key_out   = key;
    assign state_dbg = state;

endmodule

// File: tb/tb_scramble_cipher_gen.sv
// Self-checking bench for scramble_cipher_gen: scoreboard of expected x_out values fed by a
// small integer reference model of the cipher and key counter.
module tb_scramble_cipher_gen;
    localparam int W = 6;
    localparam int KW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  x_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [KW-1:0] key_out;
    logic [3:0]    state_dbg;
`ifdef SCRAMBLE_DROP_CNT_EN
    logic [W-1:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_key = 0;
    int m_drops = 0;
    logic [W-1:0] exp_q[$];

    scramble_cipher_gen dut (
        .clock(clock), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .x_out(x_out), .out_valid(out_valid), .out_ready(out_ready), .key_out(key_out),
`ifdef SCRAMBLE_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Reference model; kind: 0 control, 1 cipher, 2 dropped.
    function automatic void model(input int x, inout int key, output int res, output int iters,
                                  output int kind);
        int ofs_t[4] = '{-21, -42, 7, 28};
        int a;
        res = 0; iters = 0;
        if (x == 0 || x == 63) begin
            kind = 0; res = x;
            key = (key < 25) ? key + 1 : 0;
        end else if (x > 26) begin
            kind = 2;
        end else begin
            kind = 1;
            a = x[0] ? 2 * key : key;
            if (x[1]) begin
                a = x + a;
                while (a > 26) begin a -= 26; iters++; end
            end else begin
                a = x - a;
                while (a < 0) begin a += 26; iters++; end
            end
            a = a + ofs_t[(x >> 2) & 3];
            res = (a < 0) ? ((-a) % 64) : (a % 64);
        end
    endfunction

    task automatic drive_word(input logic [W-1:0] x, input int max_edges, output int lat,
                              output logic seen, output logic [W-1:0] obs);
        int guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 50) begin @(negedge clock); guard++; end
        x_in = x; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < max_edges) begin
            @(posedge clock); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        obs = x_out;
    endtask

    task automatic send(input logic [W-1:0] x, output int lat, output logic seen,
                        output logic [W-1:0] obs, output int exp_lat, output int kind);
        int res, it;
        model(int'(x), m_key, res, it, kind);
        if (kind != 2) exp_q.push_back(W'(res));
        else m_drops++;
        exp_lat = (kind == 0) ? 2 : 6 + it;
        drive_word(x, (kind == 2) ? 10 : 40, lat, seen, obs);
    endtask

    task automatic walk_key_to(input int target);
        int lat, elat, kind; logic seen; logic [W-1:0] obs, e;
        int guard = 0;
        while (m_key != target && guard < 30) begin
            send('0, lat, seen, obs, elat, kind);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            guard++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (x_out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || key_out !== '0) begin
            errors++;
            $display("FAIL reset_state x_out=%0d out_valid=%0b in_ready=%0b key=%0d want 0/0/0/0",
                     x_out, out_valid, in_ready, key_out);
        end
        @(negedge clock); reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release in_ready got %0b want 1", in_ready);
        end
        m_key = 0;
    endtask

    task automatic test_cipher_basic();
        int lat, elat, kind; logic seen; logic [W-1:0] obs, e;
        send(6'd5, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e || obs !== 6'd37) begin
            errors++; $display("FAIL cipher5 x_out got %0d seen %0b want %0d", obs, seen, e);
        end
        checks++;
        if (lat !== 6) begin errors++; $display("FAIL cipher5_lat got %0d want 6", lat); end
    endtask

    task automatic test_control();
        int lat, elat, kind; logic seen; logic [W-1:0] obs, e;
        send(6'd0, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e || lat !== 2) begin
            errors++; $display("FAIL ctrl0 x_out got %0d lat %0d want %0d lat 2", obs, lat, e);
        end
        checks++;
        if (key_out !== KW'(m_key) || key_out !== 5'd1) begin
            errors++; $display("FAIL ctrl0_key got %0d want %0d", key_out, m_key);
        end
        send(6'd3, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e || obs !== 6'd16 || lat !== elat) begin
            errors++; $display("FAIL cipher3 x_out got %0d lat %0d want %0d lat %0d", obs, lat, e, elat);
        end
    endtask

    task automatic test_key_wrap();
        int lat, elat, kind; logic seen; logic [W-1:0] obs, e;
        walk_key_to(25);
        checks++;
        if (key_out !== 5'd25) begin errors++; $display("FAIL key_max got %0d want 25", key_out); end
        send(6'd26, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e || obs !== 6'd32 || lat !== 7) begin
            errors++; $display("FAIL cipher26 x_out got %0d lat %0d want %0d lat 7", obs, lat, e);
        end
        send(6'd63, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e || key_out !== '0) begin
            errors++; $display("FAIL key_wrap x_out %0d key %0d want %0d key 0", obs, key_out, e);
        end
    endtask

    task automatic test_rsot();
        int lat, elat, kind; logic seen; logic [W-1:0] obs, e;
        walk_key_to(25);
        send(6'd1, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e || obs !== 6'd18) begin
            errors++; $display("FAIL cipher1_rsot x_out got %0d want %0d", obs, e);
        end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL cipher1_lat got %0d want 8", lat); end
    endtask

    task automatic test_drop();
        int rdy_at = 0; logic saw = 1'b0; int guard = 0;
        int res, it, kind;
        model(27, m_key, res, it, kind);
        m_drops++;
        @(negedge clock);
        while (!in_ready && guard < 50) begin @(negedge clock); guard++; end
        x_in = 6'd27; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clock); #1;
            if (in_ready && rdy_at == 0) rdy_at = e;
            if (out_valid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || rdy_at !== 2) begin
            errors++; $display("FAIL drop27 out_valid_seen %0b in_ready_edge %0d want 0/2", saw, rdy_at);
        end
`ifdef SCRAMBLE_DROP_CNT_EN
        checks++;
        if (drop_cnt !== W'(m_drops)) begin
            errors++; $display("FAIL drop_cnt got %0d want %0d", drop_cnt, m_drops);
        end
`endif
    endtask

    task automatic test_backpressure();
        int lat, elat, kind, bad = 0; logic seen; logic [W-1:0] obs, e;
        out_ready = 1'b0;
        send(6'd9, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e) begin
            errors++; $display("FAIL bp_value x_out got %0d want %0d", obs, e);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (x_out !== e || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold unstable_cycles got %0d want 0", bad); end
        out_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b0 || x_out !== e) begin
            errors++; $display("FAIL bp_release out_valid %0b x_out %0d want 0 / %0d", out_valid, x_out, e);
        end
    endtask

    task automatic test_reset_mid();
        int lat, elat, kind; logic seen; logic [W-1:0] obs, e;
        int guard = 0;
        walk_key_to(24);
        send(6'd63, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        @(negedge clock);
        while (!in_ready && guard < 50) begin @(negedge clock); guard++; end
        x_in = 6'd1; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (x_out !== '0 || out_valid !== 1'b0 || key_out !== '0) begin
            errors++; $display("FAIL reset_mid x_out %0d out_valid %0b key %0d want 0/0/0", x_out, out_valid, key_out);
        end
        m_key = 0;
        @(negedge clock); reset = 1'b1;
        send(6'd5, lat, seen, obs, elat, kind);
        e = exp_q.pop_front();
        checks++;
        if (!seen || obs !== e || lat !== elat) begin
            errors++; $display("FAIL after_reset x_out got %0d lat %0d want %0d lat %0d", obs, lat, e, elat);
        end
    endtask

    task automatic test_random();
        int lat, elat, kind; logic seen; logic [W-1:0] obs, e, x;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom_range(0, 63));
            if (i % 5 == 0) x = W'($urandom_range(0, 1) * 63);
            send(x, lat, seen, obs, elat, kind);
            checks++;
            if (kind == 2) begin
                if (seen) begin errors++; $display("FAIL rand_drop x_in %0d produced output", x); end
            end else begin
                e = exp_q.pop_front();
                if (!seen || obs !== e || lat !== elat || key_out !== KW'(m_key)) begin
                    errors++;
                    $display("FAIL rand x_in %0d x_out %0d lat %0d key %0d want %0d lat %0d key %0d",
                             x, obs, lat, key_out, e, elat, m_key);
                end
            end
        end
`ifdef SCRAMBLE_DROP_CNT_EN
        checks++;
        if (drop_cnt !== W'(m_drops)) begin
            errors++; $display("FAIL rand_drop_cnt got %0d want %0d", drop_cnt, m_drops);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cipher_basic();
        test_control();
        test_key_wrap();
        test_rsot();
        test_drop();
        test_backpressure();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
